// File: rtl/sum_window_avg_pkg.sv
// Shared constants for the adder output stream and its window averager.
// sum_width() is the single source of truth for the accumulator width.
package sum_window_avg_pkg;

    localparam int DEFAULT_WIDTH      = 6;
    localparam int DEFAULT_DEPTH_LOG2 = 3;

    function automatic int sum_width(input int width, input int depth_log2);
        return width + depth_log2;
    endfunction

endpackage

// File: rtl/sum_window_avg_sample_ring.sv
// Circular buffer of the last 2**DEPTH_LOG2 samples. The entry about to be
// overwritten is presented combinationally so the caller can subtract it.
module sample_ring
    import sum_window_avg_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] evict_o
);

    localparam int N = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      ring_q [N];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;

    assign evict_o = ring_q[wr_ptr_q];

    // Pointer wraps N-1 -> 0 through natural overflow of its DEPTH_LOG2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            ring_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/sum_window_avg.sv
// Sliding-window sum and average over the last 2**DEPTH_LOG2 accepted samples.
// The window state is implicit: FILLING while count < N, FULL once it saturates.
module sum_window_avg
    import sum_window_avg_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [WIDTH-1:0]                      in_data,
    input  logic                                  clear,
    output logic                                  out_valid,
    output logic [sum_width(WIDTH,DEPTH_LOG2)-1:0] out_sum,
    output logic [WIDTH-1:0]                      out_avg,
    output logic                                  filled
);

    localparam int SW    = sum_width(WIDTH, DEPTH_LOG2);
    localparam int N     = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic             accept;
    logic [WIDTH-1:0] oldest;

    logic [SW-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             filled_q, filled_d;
    logic             valid_q;

    // Clear takes priority over a same-cycle sample, which is dropped.
    assign accept = in_valid && !clear;

    sample_ring #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept),
        .clear_i   (clear),
        .wr_data_i (in_data),
        .evict_o   (oldest)
    );

    // Empty slots read zero, so subtracting the evicted entry is correct
    // even while the window is still filling.
    always_comb begin
        sum_d    = sum_q + SW'(in_data) - SW'(oldest);
        count_d  = (count_q == CNT_W'(N)) ? count_q : count_q + 1'b1;
        filled_d = (count_d == CNT_W'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            count_q  <= '0;
            filled_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (clear) begin
            sum_q    <= '0;
            count_q  <= '0;
            filled_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (accept) begin
            sum_q    <= sum_d;
            count_q  <= count_d;
            filled_q <= filled_d;
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_avg   = sum_q[SW-1:DEPTH_LOG2];
    assign filled    = filled_q;

endmodule

// File: tb/tb_sum_window_avg.sv
// Self-checking bench for sum_window_avg: directed vector table, corner
// sequences, and random traffic against a queue-based window model.
module tb_sum_window_avg;

    localparam int WIDTH      = 6;
    localparam int DEPTH_LOG2 = 3;
    localparam int N          = 1 << DEPTH_LOG2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] in_data;
    logic       clear;
    logic       out_valid;
    logic [8:0] out_sum;
    logic [5:0] out_avg;
    logic       filled;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit valid;
        bit clr;
        int data;
        bit expValid;
        int expSum;
        bit expFilled;
    } vec_t;

    vec_t vecs[$];
    int   window[$];
    bit   modelValid;

    sum_window_avg #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .filled    (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelSum();
        int s = 0;
        foreach (window[i]) s += window[i];
        return s;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input bit v, input bit c, input int d,
                          input bit ev, input int es, input bit ef);
        vec_t t;
        t.valid = v; t.clr = c; t.data = d;
        t.expValid = ev; t.expSum = es; t.expFilled = ef;
        vecs.push_back(t);
    endtask

    // Drive one cycle, update the model from the window rules, sample #1 after the edge.
    task automatic applyStimulus(input bit v, input bit c, input int d);
        in_valid = v;
        clear    = c;
        in_data  = 6'(d);
        if (c) begin
            window.delete();
            modelValid = 1'b0;
        end else if (v) begin
            window.push_back(d);
            if (window.size() > N) void'(window.pop_front());
            modelValid = 1'b1;
        end else begin
            modelValid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int s;
        s = modelSum();
        check({tag, ".valid"},  int'(out_valid), int'(modelValid));
        check({tag, ".sum"},    int'(out_sum),   s);
        check({tag, ".avg"},    int'(out_avg),   s / N);
        check({tag, ".filled"}, int'(filled),    int'(window.size() == N));
    endtask

    initial begin
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        rst_n    = 1'b0;
        #2;
        check("reset.sum",    int'(out_sum),   0);
        check("reset.valid",  int'(out_valid), 0);
        check("reset.filled", int'(filled),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight 60s fill the window, one 0 evicts the first 60.
        for (int i = 1; i <= 8; i++) addVec(1, 0, 60, 1, 60 * i, i == 8);
        addVec(1, 0, 0, 1, 420, 1);
        addVec(0, 1, 0, 0, 0, 0);
        addVec(1, 0, 5, 1, 5, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 5, 0);
        addVec(1, 0, 7, 1, 12, 0);
        addVec(1, 1, 20, 0, 0, 0);
        addVec(1, 0, 10, 1, 10, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].clr, vecs[i].data);
            check($sformatf("vec%0d.valid", i),  int'(out_valid), int'(vecs[i].expValid));
            check($sformatf("vec%0d.sum", i),    int'(out_sum),   vecs[i].expSum);
            check($sformatf("vec%0d.avg", i),    int'(out_avg),   vecs[i].expSum >> 3);
            check($sformatf("vec%0d.filled", i), int'(filled),    int'(vecs[i].expFilled));
        end

        // Saturating window of 63s, then pointer wrap with eight 1s.
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 63);
            checkOutput($sformatf("max%0d", i));
        end
        check("max.sum", int'(out_sum), 504);
        check("max.avg", int'(out_avg), 63);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1);
        check("wrap.sum", int'(out_sum), 8);
        check("wrap.avg", int'(out_avg), 1);
        check("wrap.filled", int'(filled), 1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 25) == 0, int'($urandom % 64));
            checkOutput($sformatf("rnd%0d", i));
        end

        // Asynchronous reset between edges with a loaded window.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 30 + i);
        in_valid = 1'b1;
        in_data  = 6'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check("async.sum",    int'(out_sum),   0);
        check("async.avg",    int'(out_avg),   0);
        check("async.valid",  int'(out_valid), 0);
        check("async.filled", int'(filled),    0);
        in_valid = 1'b0;
        window.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 17);
        checkOutput("postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
